// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM state encoding and
// chunk-index width helper.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Chunk index needs clog2(n) bits, but never fewer than one.
  function automatic int unsigned chunk_idx_width(int unsigned n_chunks);
    return (n_chunks <= 1) ? 1 : $clog2(n_chunks);
  endfunction

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_CHUNK = 4;
  localparam int unsigned CHUNK_IDX_W   = chunk_idx_width(DEFAULT_WIDTH / DEFAULT_CHUNK);

endpackage

// File: rtl/rca_n_bit.sv
// Purely combinational N-bit ripple-carry adder built from full adders.
module rca_n_bit #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out
);

  logic [N:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[N];

endmodule

// File: rtl/seq_chunk_adder.sv
// Sequential adder/subtractor: processes CHUNK bits per cycle LSB-first,
// pulsing done once the full WIDTH-bit result, carry and overflow are valid.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned N_CHUNKS = WIDTH / CHUNK;
  localparam int unsigned IDX_W    = chunk_idx_width(N_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] chunk_idx_q, chunk_idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_lat_q, a_lat_d;
  logic [WIDTH-1:0] b_eff_q, b_eff_d;
  logic [WIDTH-1:0] s_d;
  logic             c_out_d, ovf_d, busy_d, done_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             sum_carry;

  // Select the active chunk of the latched operands.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < N_CHUNKS; i++) begin
      if (chunk_idx_q == IDX_W'(i)) begin
        a_chunk = a_lat_q[i*CHUNK +: CHUNK];
        b_chunk = b_eff_q[i*CHUNK +: CHUNK];
      end
    end
  end

  rca_n_bit #(
    .N (CHUNK)
  ) u_rca (
    .a     (a_chunk),
    .b     (b_chunk),
    .c_in  (carry_q),
    .s     (sum_chunk),
    .c_out (sum_carry)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    chunk_idx_d = chunk_idx_q;
    carry_d     = carry_q;
    a_lat_d     = a_lat_q;
    b_eff_d     = b_eff_q;
    s_d         = s;
    c_out_d     = c_out;
    ovf_d       = ovf;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_lat_d     = a;
          b_eff_d     = b ^ {WIDTH{sub}};
          carry_d     = sub ? 1'b1 : c_in;
          chunk_idx_d = '0;
          state_d     = ST_RUN;
          busy_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        busy_d  = 1'b1;
        carry_d = sum_carry;
        for (int unsigned i = 0; i < N_CHUNKS; i++) begin
          if (chunk_idx_q == IDX_W'(i)) begin
            s_d[i*CHUNK +: CHUNK] = sum_chunk;
          end
        end
        if (chunk_idx_q == LAST_IDX) begin
          // The top chunk holds the result MSB, so overflow is known here.
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          chunk_idx_d = '0;
          c_out_d     = sum_carry;
          ovf_d       = (a_lat_q[WIDTH-1] == b_eff_q[WIDTH-1]) &&
                        (sum_chunk[CHUNK-1] != a_lat_q[WIDTH-1]);
        end else begin
          chunk_idx_d = chunk_idx_q + IDX_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      chunk_idx_q <= '0;
      carry_q     <= 1'b0;
      a_lat_q     <= '0;
      b_eff_q     <= '0;
      s           <= '0;
      c_out       <= 1'b0;
      ovf         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      chunk_idx_q <= chunk_idx_d;
      carry_q     <= carry_d;
      a_lat_q     <= a_lat_d;
      b_eff_q     <= b_eff_d;
      s           <= s_d;
      c_out       <= c_out_d;
      ovf         <= ovf_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule
